// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl
// Clocked external-bus controller. Arbitrates CPU and DMA requests (DMA wins
// when both are pending in IDLE) and runs each access as a sequenced bus
// cycle: address setup, strobe with programmable wait states, hold.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack    registered CPU read data; one-cycle completion pulse
//   dma_req/addr          DMA read request (level, held until dma_ack)
//   dma_rdata, dma_ack    registered DMA read data; one-cycle completion pulse
//   dma_gnt               high while a DMA cycle owns the bus
//   cfg_ws                wait states, sampled when a request is accepted
//   ext_a, ext_d_out/oe   external address pins, data out and its enable
//   ext_d_in              external data in
//   ext_nrd/nwr/ncs       active-low read strobe, write strobe, chip select
module ext_bus_ctrl #(
  parameter int unsigned    AW     = 16,
  parameter int unsigned    DW     = 8,
  parameter int unsigned    WSW    = 2,
  parameter logic [AW-1:0]  CS_LO  = 16'hA000,
  parameter logic [AW-1:0]  CS_HI  = 16'hFDFF,
  parameter logic [AW-1:0]  A_IDLE = 16'h0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_ack,
  input  logic           dma_req,
  input  logic [AW-1:0]  dma_addr,
  output logic [DW-1:0]  dma_rdata,
  output logic           dma_ack,
  output logic           dma_gnt,
  input  logic [WSW-1:0] cfg_ws,
  output logic [AW-1:0]  ext_a,
  output logic [DW-1:0]  ext_d_out,
  output logic           ext_d_oe,
  input  logic [DW-1:0]  ext_d_in,
  output logic           ext_nrd,
  output logic           ext_nwr,
  output logic           ext_ncs
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [WSW-1:0] wc_q, wc_d;
  logic           dma_own_q, dma_own_d;   // 1: current cycle belongs to DMA
  logic           we_q, we_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]  dma_rdata_q, dma_rdata_d;

  logic active;
  logic in_win;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= A_IDLE;
      wdata_q     <= '0;
      wc_q        <= '0;
      dma_own_q   <= 1'b0;
      we_q        <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wc_q        <= wc_d;
      dma_own_q   <= dma_own_d;
      we_q        <= we_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Window compare on the latched address; CS_LO > CS_HI can never match.
  assign active = (state_q != IDLE);
  assign in_win = (addr_q >= CS_LO) && (addr_q <= CS_HI);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wc_d        = wc_q;
    dma_own_d   = dma_own_q;
    we_d        = we_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    ext_nrd = 1'b1;
    ext_nwr = 1'b1;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dma_req) begin
          addr_d    = dma_addr;
          wdata_d   = cpu_wdata;
          wc_d      = cfg_ws;
          dma_own_d = 1'b1;
          we_d      = 1'b0;
          state_d   = SETUP;
        end else if (cpu_req) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          wc_d      = cfg_ws;
          dma_own_d = 1'b0;
          we_d      = cpu_we;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        ext_nrd = we_q;
        state_d = STROBE;
      end
      STROBE: begin
        ext_nrd = we_q;
        ext_nwr = ~we_q;
        if (wc_q == '0) begin
          state_d = HOLD;
          // Read data is sampled on the edge that ends the strobe.
          if (!we_q) begin
            if (dma_own_q) dma_rdata_d = ext_d_in;
            else           cpu_rdata_d = ext_d_in;
          end
        end else begin
          wc_d = wc_q - WSW'(1);
        end
      end
      HOLD: begin
        cpu_ack = ~dma_own_q;
        dma_ack = dma_own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ext_a     = addr_q;
  assign ext_d_out = wdata_q;
  assign ext_d_oe  = active & we_q;
  assign ext_ncs   = ~(active & in_win);
  assign dma_gnt   = active & dma_own_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_ext_bus_ctrl.sv
module tb_ext_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        dma_ack, dma_gnt;
  logic [1:0]  cfg_ws;
  logic [15:0] ext_a;
  logic [7:0]  ext_d_out, ext_d_in;
  logic        ext_d_oe, ext_nrd, ext_nwr, ext_ncs;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         dma;
    logic [7:0] rdata;
  } sb_t;
  sb_t sbq[$];

  // Reference copies of the two read-data registers.
  logic [7:0] cpu_m = 8'h00;
  logic [7:0] dma_m = 8'h00;

  ext_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .dma_gnt   (dma_gnt),
    .cfg_ws    (cfg_ws),
    .ext_a     (ext_a),
    .ext_d_out (ext_d_out),
    .ext_d_oe  (ext_d_oe),
    .ext_d_in  (ext_d_in),
    .ext_nrd   (ext_nrd),
    .ext_nwr   (ext_nwr),
    .ext_ncs   (ext_ncs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [15:0] addr);
    chk({tag, "_a"},   32'(ext_a), 32'(addr));
    chk({tag, "_nrd"}, 32'(ext_nrd), 32'd1);
    chk({tag, "_nwr"}, 32'(ext_nwr), 32'd1);
    chk({tag, "_ncs"}, 32'(ext_ncs), 32'd1);
    chk({tag, "_oe"},  32'(ext_d_oe), 32'd0);
    chk({tag, "_cack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_dack"}, 32'(dma_ack), 32'd0);
    chk({tag, "_gnt"}, 32'(dma_gnt), 32'd0);
  endtask

  task automatic sb_check;
    sb_t e;
    if (cpu_ack || dma_ack) begin
      chk("sb_pending", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_owner", 32'(dma_ack), 32'(e.dma));
        chk("sb_rdata", 32'(e.dma ? dma_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
  endtask

  // Drives one request (accepted at the next edge, bus assumed idle) and
  // checks every cycle through HOLD and the following IDLE cycle.
  task automatic run_access(input bit dma, input bit we, input logic [15:0] addr,
                            input logic [7:0] wdata, input logic [1:0] ws,
                            input logic [7:0] din, input int raise_at,
                            input logic [15:0] raise_addr);
    int   last;
    logic exp_ncs;
    logic [7:0] exp_rd;
    sb_t  e;
    last    = 3 + int'(ws);
    exp_ncs = !((addr >= 16'hA000) && (addr <= 16'hFDFF));
    if (dma) begin
      dma_req = 1'b1; dma_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    cfg_ws   = ws;
    ext_d_in = din;
    exp_rd   = we ? cpu_m : din;
    e.dma = dma; e.rdata = exp_rd;
    sbq.push_back(e);
    for (int n = 1; n <= last; n++) begin
      tick();
      chk("cyc_a",   32'(ext_a), 32'(addr));
      chk("cyc_nrd", 32'(ext_nrd), 32'((!we && n <= last - 1) ? 1'b0 : 1'b1));
      chk("cyc_nwr", 32'(ext_nwr), 32'((we && n >= 2 && n <= last - 1) ? 1'b0 : 1'b1));
      chk("cyc_oe",  32'(ext_d_oe), 32'(we));
      chk("cyc_ncs", 32'(ext_ncs), 32'(exp_ncs));
      chk("cyc_gnt", 32'(dma_gnt), 32'(dma));
      chk("cyc_cack", 32'(cpu_ack), 32'(!dma && n == last));
      chk("cyc_dack", 32'(dma_ack), 32'(dma && n == last));
      if (we) chk("cyc_dout", 32'(ext_d_out), 32'(wdata));
      chk("cyc_crd", 32'(cpu_rdata), 32'((!dma && !we && n == last) ? din : cpu_m));
      chk("cyc_drd", 32'(dma_rdata), 32'((dma && n == last) ? din : dma_m));
      sb_check();
      if (n == 1) begin
        // Post-acceptance changes must not disturb the running cycle.
        cfg_ws = ~ws;
        if (dma) dma_addr = ~addr;
        else begin cpu_addr = ~addr; cpu_wdata = ~wdata; end
      end
      if (n == raise_at) begin
        dma_req  = 1'b1;
        dma_addr = raise_addr;
      end
    end
    if (dma) dma_m = din;
    else if (!we) cpu_m = din;
    tick();
    if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
    chk_idle_outputs("idle", addr);
  endtask

  task automatic chk_reset_values(input string tag);
    chk_idle_outputs(tag, 16'h0000);
    chk({tag, "_dout"}, 32'(ext_d_out), 32'd0);
    chk({tag, "_crd"},  32'(cpu_rdata), 32'd0);
    chk({tag, "_drd"},  32'(dma_rdata), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; cfg_ws = '0; ext_d_in = '0;
    #3;
    chk_reset_values("rst");
    tick(); tick();
    reset = 1'b0;
    chk_reset_values("post_rst");

    // CPU read outside the chip-select window, no wait states.
    run_access(1'b0, 1'b0, 16'h4000, 8'h00, 2'd0, 8'h5A, 0, 16'h0);
    // CPU write inside the window, two wait states.
    run_access(1'b0, 1'b1, 16'hA123, 8'hC3, 2'd2, 8'h00, 0, 16'h0);

    // Simultaneous requests: DMA first, CPU accepted after the IDLE cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    run_access(1'b1, 1'b0, 16'hC000, 8'h00, 2'd1, 8'h3C, 0, 16'h0);
    run_access(1'b0, 1'b0, 16'h0100, 8'h00, 2'd0, 8'h96, 0, 16'h0);

    // DMA request arriving during a CPU strobe waits for the CPU cycle.
    run_access(1'b0, 1'b0, 16'h0200, 8'h00, 2'd2, 8'h11, 2, 16'hD000);
    run_access(1'b1, 1'b0, 16'hD000, 8'h00, 2'd0, 8'hE7, 0, 16'h0);

    // Chip-select window edges.
    run_access(1'b0, 1'b0, 16'h9FFF, 8'h00, 2'd0, 8'h21, 0, 16'h0);
    run_access(1'b0, 1'b0, 16'hA000, 8'h00, 2'd0, 8'h42, 0, 16'h0);
    run_access(1'b0, 1'b0, 16'hFDFF, 8'h00, 2'd0, 8'h84, 0, 16'h0);
    run_access(1'b0, 1'b0, 16'hFE00, 8'h00, 2'd0, 8'h18, 0, 16'h0);

    // Reset in the middle of a ws=3 write strobe.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hB000; cpu_wdata = 8'h77; cfg_ws = 2'd3;
    tick();
    chk("abort_setup_ncs", 32'(ext_ncs), 32'd0);
    tick();
    chk("abort_strobe_nwr", 32'(ext_nwr), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk_reset_values("abort");
    cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    cpu_m = 8'h00; dma_m = 8'h00;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_ack", 32'(cpu_ack), 32'd0);
      tick();
    end
    run_access(1'b0, 1'b0, 16'hA800, 8'h00, 2'd1, 8'h6B, 0, 16'h0);
    run_access(1'b0, 1'b1, 16'hA801, 8'h5D, 2'd0, 8'h00, 0, 16'h0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
Parametrised, clocked external-bus controller, successor to the combinational external CPU/DMA bus pin logic. It arbitrates CPU and DMA requests and runs each external access as a sequenced bus cycle. The cycle has address setup, a strobe with programmable wait states, and a hold phase. Read data is registered and chip-select is decoded from a parametrised window. It sits between the CPU/DMA address/data busses and the cartridge pins.

Parameters:
AW, 16, address width (bits)
DW, 8, data width (bits)
WSW, 2, width of wait-state config (0..2^WSW-1 extra strobe cycles)
CS_LO, 16'hA000, lowest address asserting ext_ncs
CS_HI, 16'hFDFF, highest address asserting ext_ncs
A_IDLE, 16'h0000, address driven during and after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; valid with cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  registered read data
cpu_ack  out  1  one-cycle completion pulse for CPU access
dma_req  in  1  DMA read request, level, held until dma_ack
dma_addr  in  AW  DMA source address
dma_rdata  out  DW  registered DMA read data
dma_ack  out  1  one-cycle completion pulse for DMA access
dma_gnt  out  1  high while a DMA cycle owns the bus
cfg_ws  in  WSW  wait states; sampled at acceptance
ext_a  out  AW  external address pins
ext_d_out  out  DW  external data out
ext_d_oe  out  1  external data output enable
ext_d_in  in  DW  external data in
ext_nrd  out  1  read strobe, active low
ext_nwr  out  1  write strobe, active low
ext_ncs  out  1  chip select, active low

Behaviour:
- Reset (async, immediate, including mid-cycle):
  - Values: state=IDLE, ext_a=A_IDLE, ext_d_out=0, ext_d_oe=0, ext_nrd=1, ext_nwr=1, ext_ncs=1, cpu_rdata=0, dma_rdata=0, cpu_ack=0, dma_ack=0, dma_gnt=0.
  - An aborted cycle produces no ack.
- States: IDLE, SETUP, STROBE, HOLD; wait counter wc (WSW bits).
- IDLE:
  - If dma_req, accept DMA (read), even if cpu_req is also high; DMA has priority.
  - Else if cpu_req, accept CPU.
  - On accept: latch address into ext_a, cpu_wdata into the write register, cfg_ws into wc, owner and direction; go to SETUP.
  - No accept: stay in IDLE; all strobes inactive; ext_a holds the last address.
- SETUP (1 cycle):
  - ext_ncs=0 iff CS_LO<=ext_a<=CS_HI (unsigned).
  - Read: ext_nrd=0. Write: ext_nrd=1, ext_d_oe=1.
  - Go to STROBE.
- STROBE (wc+1 cycles):
  - Write: ext_nwr=0, ext_d_oe=1. Read: ext_nrd=0.
  - wc decrements each cycle; leave when wc==0.
  - Read: on the edge leaving STROBE, ext_d_in is captured into cpu_rdata or dma_rdata (owner only).
- HOLD (1 cycle):
  - ext_nwr=1, ext_nrd=1; ext_d_oe stays 1 for writes; ext_ncs stays asserted.
  - Owner's ack=1 for this cycle only; go to IDLE.
- Cycle timing: accept edge E0; SETUP in cycle 1; STROBE in cycles 2..2+ws; HOLD/ack in cycle 3+ws. IDLE is cycle 4+ws; the next accept happens at the end of it.
- Access length: ws=0 gives a 3-cycle access plus 1 IDLE cycle.
- Handshake: a registered requester drops req at the edge ending HOLD, so it is not re-accepted. Changes to req, address or data after acceptance are ignored until ack.
- dma_gnt=1 from SETUP through HOLD of a DMA cycle. No preemption: a CPU access in progress completes before DMA.
- cfg_ws changes mid-cycle do not affect the current cycle.
- rdata registers hold their value until the next read by the same owner; writes never alter cpu_rdata.
- Address compare and ext_a are AW wide. CS_LO>CS_HI means ext_ncs is never asserted.

Test Plan:
- Reset, then CPU read 16'h4000, ws=0, ext_d_in=8'h5A: ext_nrd low cycles 1-2; ext_ncs stays 1; cpu_ack in cycle 3; cpu_rdata=8'h5A.
- CPU write 16'hA123 data 8'hC3, ws=2: ext_ncs=0 cycles 1-5; ext_nwr low exactly cycles 2-4; ext_d_oe=1 cycles 1-5; ext_d_out=8'hC3; cpu_ack in cycle 5.
- cpu_req and dma_req rise together (dma_addr 16'hC000, cpu read 16'h0100): DMA served first with dma_gnt=1, dma_ack, dma_rdata updated; the CPU cycle is accepted at the edge ending the following IDLE cycle; cpu_rdata is unchanged by the DMA.
- dma_req rises during a CPU STROBE: the CPU cycle completes unaltered; DMA SETUP starts after the IDLE cycle following cpu_ack.
- Reset pulse during STROBE of a ws=3 write: all outputs return to reset values asynchronously; no cpu_ack; a new request after reset completes normally.
- Addresses 16'h9FFF, 16'hA000, 16'hFDFF, 16'hFE00: ext_ncs asserted only for 16'hA000 and 16'hFDFF.
